// File: rtl/decode_rat_ckpt_ring_pkg.sv
// Shared defaults and width helpers for the decode RAT checkpoint ring.
package decode_rat_ckpt_ring_pkg;

  localparam int unsigned DEF_NUM_CP   = 4;
  localparam int unsigned DEF_NUM_AREG = 32;
  localparam int unsigned DEF_FID_W    = 8;
  localparam int unsigned DEF_ROB_W    = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/decode_rat_ckpt_slot.sv
// One RAT checkpoint snapshot: bulk write, fid-matched commit clear, and a
// read port that already reflects a same-cycle commit. Register 0 is not stored.
module decode_rat_ckpt_slot
  import decode_rat_ckpt_ring_pkg::*;
#(
  parameter  int unsigned NUM_AREG = DEF_NUM_AREG,
  parameter  int unsigned FID_W    = DEF_FID_W,
  parameter  int unsigned ROB_W    = DEF_ROB_W,
  localparam int unsigned AREG_W   = id_width(NUM_AREG)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_live,
  input  logic                      i_wr_en,
  input  logic [NUM_AREG-1:0]       i_wr_valid,
  input  logic [NUM_AREG*FID_W-1:0] i_wr_fid,
  input  logic [NUM_AREG*ROB_W-1:0] i_wr_rob,
  input  logic                      i_cmt_req,
  input  logic [AREG_W-1:0]         i_cmt_areg,
  input  logic [FID_W-1:0]          i_cmt_fid,
  output logic [NUM_AREG-1:0]       o_valid,
  output logic [NUM_AREG*FID_W-1:0] o_fid,
  output logic [NUM_AREG*ROB_W-1:0] o_rob
);

  logic [NUM_AREG-1:1] r_valid;
  logic [FID_W-1:0]    r_fid [NUM_AREG-1:1];
  logic [ROB_W-1:0]    r_rob [NUM_AREG-1:1];
  logic [NUM_AREG-1:1] w_hit_wr;
  logic [NUM_AREG-1:1] w_hit_rd;
  logic                w_unused_reg0;

  assign w_unused_reg0 = ^{i_wr_valid[0], i_wr_fid[FID_W-1:0], i_wr_rob[ROB_W-1:0]};

  // Commit hits against incoming (alloc) fids and against stored fids.
  always_comb begin
    w_hit_wr = '0;
    w_hit_rd = '0;
    for (int unsigned a = 1; a < NUM_AREG; a++) begin
      w_hit_wr[a] = i_cmt_req && (i_cmt_areg == AREG_W'(a)) &&
                    (i_wr_fid[a*FID_W +: FID_W] == i_cmt_fid);
      w_hit_rd[a] = i_cmt_req && (i_cmt_areg == AREG_W'(a)) &&
                    (r_fid[a] == i_cmt_fid);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid <= i_wr_valid[NUM_AREG-1:1] & ~w_hit_wr;
    end else if (i_live) begin
      r_valid <= r_valid & ~w_hit_rd;
    end
  end

  // Payload storage is intentionally left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int unsigned a = 1; a < NUM_AREG; a++) begin
        r_fid[a] <= i_wr_fid[a*FID_W +: FID_W];
        r_rob[a] <= i_wr_rob[a*ROB_W +: ROB_W];
      end
    end
  end

  always_comb begin
    o_valid = '0;
    o_fid   = '0;
    o_rob   = '0;
    for (int unsigned a = 1; a < NUM_AREG; a++) begin
      o_valid[a]               = r_valid[a] & ~w_hit_rd[a];
      o_fid[a*FID_W +: FID_W]  = r_fid[a];
      o_rob[a*ROB_W +: ROB_W]  = r_rob[a];
    end
  end

endmodule

// File: rtl/decode_rat_ckpt_ring.sv
// Age-ordered ring of RAT checkpoints: allocate at tail, release at head,
// recover to any live slot (dropping younger ones), flush drops everything.
module decode_rat_ckpt_ring
  import decode_rat_ckpt_ring_pkg::*;
#(
  parameter  int unsigned NUM_CP   = DEF_NUM_CP,
  parameter  int unsigned NUM_AREG = DEF_NUM_AREG,
  parameter  int unsigned FID_W    = DEF_FID_W,
  parameter  int unsigned ROB_W    = DEF_ROB_W,
  localparam int unsigned ID_W     = id_width(NUM_CP),
  localparam int unsigned AREG_W   = id_width(NUM_AREG),
  localparam int unsigned CNT_W    = ID_W + 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_flush,
  input  logic                      i_alloc_req,
  output logic                      o_alloc_ready,
  output logic [ID_W-1:0]           o_alloc_id,
  input  logic [NUM_AREG-1:0]       i_alloc_valid,
  input  logic [NUM_AREG*FID_W-1:0] i_alloc_fid,
  input  logic [NUM_AREG*ROB_W-1:0] i_alloc_rob,
  input  logic                      i_rec_req,
  input  logic [ID_W-1:0]           i_rec_id,
  output logic [NUM_AREG-1:0]       o_rec_valid,
  output logic [NUM_AREG*FID_W-1:0] o_rec_fid,
  output logic [NUM_AREG*ROB_W-1:0] o_rec_rob,
  input  logic                      i_cmt_req,
  input  logic [AREG_W-1:0]         i_cmt_areg,
  input  logic [FID_W-1:0]          i_cmt_fid,
  input  logic                      i_rel_req,
  input  logic [ID_W-1:0]           i_rel_id,
  output logic [NUM_CP-1:0]         o_cp_valid,
  output logic [CNT_W-1:0]          o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_err
);

  logic [ID_W-1:0]   r_head;
  logic [ID_W-1:0]   r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [NUM_CP-1:0] r_cp_valid;
  logic              r_err;

  logic [ID_W-1:0]   w_head_nxt;
  logic [ID_W-1:0]   w_tail_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [NUM_CP-1:0] w_cp_nxt;
  logic              w_err_set;

  logic              w_full;
  logic              w_empty;
  logic              w_alloc_ready;
  logic              w_alloc_fire;
  logic              w_rec_ok;
  logic              w_rel_ok;
  logic [ID_W-1:0]   w_rec_off;
  logic [NUM_CP-1:0] w_wr_en;

  logic [NUM_AREG-1:0]       w_slot_valid [NUM_CP];
  logic [NUM_AREG*FID_W-1:0] w_slot_fid   [NUM_CP];
  logic [NUM_AREG*ROB_W-1:0] w_slot_rob   [NUM_CP];

  // Ready depends only on registered occupancy, never on a same-cycle release.
  assign w_full        = (r_count == CNT_W'(NUM_CP));
  assign w_empty       = (r_count == '0);
  assign w_alloc_ready = !w_full && !i_rec_req && !i_flush;
  assign w_alloc_fire  = i_alloc_req && w_alloc_ready;
  assign w_rec_ok      = i_rec_req && r_cp_valid[i_rec_id];
  assign w_rel_ok      = i_rel_req && !w_empty && (i_rel_id == r_head) && r_cp_valid[r_head];
  assign w_rec_off     = ID_W'(i_rec_id - r_head);

  assign w_err_set = (i_rec_req && !r_cp_valid[i_rec_id]) ||
                     (i_rel_req && (w_empty || (i_rel_id != r_head))) ||
                     (i_alloc_req && w_full);

  // Next ring state; flush wins over recover, recover over release, then alloc.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    w_cp_nxt    = r_cp_valid;
    if (i_flush) begin
      w_cp_nxt    = '0;
      w_count_nxt = '0;
      w_head_nxt  = r_tail;
    end else begin
      if (w_rec_ok) begin
        for (int unsigned i = 0; i < NUM_CP; i++) begin
          if (ID_W'(ID_W'(i) - r_head) >= w_rec_off) begin
            w_cp_nxt[i] = 1'b0;
          end
        end
        w_tail_nxt  = i_rec_id;
        w_count_nxt = CNT_W'(w_rec_off);
      end
      // Recovering to the head itself already empties the ring.
      if (w_rel_ok && !(w_rec_ok && (i_rec_id == r_head))) begin
        w_cp_nxt[r_head] = 1'b0;
        w_head_nxt       = ID_W'(r_head + 1'b1);
        w_count_nxt      = CNT_W'(w_count_nxt - 1'b1);
      end
      if (w_alloc_fire) begin
        w_cp_nxt[r_tail] = 1'b1;
        w_tail_nxt       = ID_W'(r_tail + 1'b1);
        w_count_nxt      = CNT_W'(w_count_nxt + 1'b1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_cp_valid <= '0;
      r_err      <= 1'b0;
    end else begin
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_count    <= w_count_nxt;
      r_cp_valid <= w_cp_nxt;
      r_err      <= r_err | w_err_set;
    end
  end

  for (genvar g = 0; g < NUM_CP; g++) begin : g_slot
    assign w_wr_en[g] = w_alloc_fire && (r_tail == ID_W'(g)) && !i_reset;

    decode_rat_ckpt_slot #(
      .NUM_AREG (NUM_AREG),
      .FID_W    (FID_W),
      .ROB_W    (ROB_W)
    ) u_slot (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_live     (r_cp_valid[g]),
      .i_wr_en    (w_wr_en[g]),
      .i_wr_valid (i_alloc_valid),
      .i_wr_fid   (i_alloc_fid),
      .i_wr_rob   (i_alloc_rob),
      .i_cmt_req  (i_cmt_req),
      .i_cmt_areg (i_cmt_areg),
      .i_cmt_fid  (i_cmt_fid),
      .o_valid    (w_slot_valid[g]),
      .o_fid      (w_slot_fid[g]),
      .o_rob      (w_slot_rob[g])
    );
  end

  assign o_rec_valid   = w_slot_valid[i_rec_id];
  assign o_rec_fid     = w_slot_fid[i_rec_id];
  assign o_rec_rob     = w_slot_rob[i_rec_id];
  assign o_alloc_ready = w_alloc_ready;
  assign o_alloc_id    = r_tail;
  assign o_cp_valid    = r_cp_valid;
  assign o_count       = r_count;
  assign o_full        = w_full;
  assign o_empty       = w_empty;
  assign o_err         = r_err;

endmodule

// File: tb/tb_decode_rat_ckpt_ring.sv
// Directed bench for the RAT checkpoint ring with default parameters.
module tb_decode_rat_ckpt_ring;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         alloc_req;
  logic         alloc_ready;
  logic [1:0]   alloc_id;
  logic [31:0]  alloc_valid;
  logic [255:0] alloc_fid;
  logic [127:0] alloc_rob;
  logic         rec_req;
  logic [1:0]   rec_id;
  logic [31:0]  rec_valid;
  logic [255:0] rec_fid;
  logic [127:0] rec_rob;
  logic         cmt_req;
  logic [4:0]   cmt_areg;
  logic [7:0]   cmt_fid;
  logic         rel_req;
  logic [1:0]   rel_id;
  logic [3:0]   cp_valid;
  logic [2:0]   count;
  logic         full;
  logic         empty;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_rat_ckpt_ring dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_flush       (flush),
    .i_alloc_req   (alloc_req),
    .o_alloc_ready (alloc_ready),
    .o_alloc_id    (alloc_id),
    .i_alloc_valid (alloc_valid),
    .i_alloc_fid   (alloc_fid),
    .i_alloc_rob   (alloc_rob),
    .i_rec_req     (rec_req),
    .i_rec_id      (rec_id),
    .o_rec_valid   (rec_valid),
    .o_rec_fid     (rec_fid),
    .o_rec_rob     (rec_rob),
    .i_cmt_req     (cmt_req),
    .i_cmt_areg    (cmt_areg),
    .i_cmt_fid     (cmt_fid),
    .i_rel_req     (rel_req),
    .i_rel_id      (rel_id),
    .o_cp_valid    (cp_valid),
    .o_count       (count),
    .o_full        (full),
    .o_empty       (empty),
    .o_err         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0; alloc_req = 1'b0; rec_req = 1'b0; rel_req = 1'b0; cmt_req = 1'b0;
    alloc_valid = '0; alloc_fid = '0; alloc_rob = '0;
    cmt_areg = '0; cmt_fid = '0; rel_id = '0;
  endtask

  initial begin
    idle();
    rec_id = '0;
    reset  = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_cp_valid", 32'(cp_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_ready", 32'(alloc_ready), 32'h1);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_alloc_id", 32'(alloc_id), 32'h0);

    // slot 0: areg5 fid 3A rob 9, areg7 fid 22
    alloc_req = 1'b1;
    alloc_valid = 32'h0000_00A0;
    alloc_fid[5*8 +: 8] = 8'h3A;
    alloc_fid[7*8 +: 8] = 8'h22;
    alloc_rob[5*4 +: 4] = 4'h9;
    chk("a0_id", 32'(alloc_id), 32'h0);
    tick();
    idle();
    chk("a0_cp_valid", 32'(cp_valid), 32'h1);
    chk("a0_count", 32'(count), 32'h1);

    // commit areg5 fid 3A, seen in rec_valid the same cycle
    rec_id = 2'd0; cmt_req = 1'b1; cmt_areg = 5'd5; cmt_fid = 8'h3A;
    #1;
    chk("cmt_bypass_valid", rec_valid, 32'h0000_0080);
    chk("cmt_rec_fid5", 32'(rec_fid[5*8 +: 8]), 32'h3A);
    chk("cmt_rec_rob5", 32'(rec_rob[5*4 +: 4]), 32'h9);
    tick();
    idle();
    chk("cmt_held_valid", rec_valid, 32'h0000_0080);

    // commit with non-matching fid leaves areg7 alone
    cmt_req = 1'b1; cmt_areg = 5'd7; cmt_fid = 8'h23;
    #1;
    chk("cmt_nomatch_bypass", rec_valid, 32'h0000_0080);
    tick();
    idle();
    chk("cmt_nomatch_held", rec_valid, 32'h0000_0080);

    // slot 1: alloc + commit areg7 fid 11 same cycle; reg0 never reads valid
    alloc_req = 1'b1;
    alloc_valid = 32'h0000_0089;
    alloc_fid[7*8 +: 8] = 8'h11;
    alloc_fid[3*8 +: 8] = 8'h44;
    cmt_req = 1'b1; cmt_areg = 5'd7; cmt_fid = 8'h11;
    chk("a1_id", 32'(alloc_id), 32'h1);
    tick();
    idle();
    rec_id = 2'd1;
    #1;
    chk("a1_cmt_valid", rec_valid, 32'h0000_0008);
    chk("a1_fid3", 32'(rec_fid[3*8 +: 8]), 32'h44);
    rec_id = 2'd0;
    #1;
    chk("a1_slot0_untouched", rec_valid, 32'h0000_0080);

    // slots 2 and 3 fill the ring
    alloc_req = 1'b1;
    chk("a2_id", 32'(alloc_id), 32'h2);
    tick();
    chk("a3_id", 32'(alloc_id), 32'h3);
    tick();
    idle();
    chk("full_count", 32'(count), 32'h4);
    chk("full_full", 32'(full), 32'h1);
    chk("full_ready", 32'(alloc_ready), 32'h0);
    chk("full_cp_valid", 32'(cp_valid), 32'hF);
    chk("full_alloc_id", 32'(alloc_id), 32'h0);

    // release head 0 and recover to slot 1 in the same cycle
    rel_req = 1'b1; rel_id = 2'd0; rec_req = 1'b1; rec_id = 2'd1;
    tick();
    idle();
    rec_req = 1'b0;
    chk("relrec_count", 32'(count), 32'h0);
    chk("relrec_empty", 32'(empty), 32'h1);
    chk("relrec_err", 32'(err), 32'h0);
    chk("relrec_cp_valid", 32'(cp_valid), 32'h0);
    chk("relrec_alloc_id", 32'(alloc_id), 32'h1);

    // walk head to 2: alloc 1, then alloc 2 with release 1
    alloc_req = 1'b1;
    tick();
    rel_req = 1'b1; rel_id = 2'd1;
    chk("allocrel_ready", 32'(alloc_ready), 32'h1);
    chk("allocrel_id", 32'(alloc_id), 32'h2);
    tick();
    rel_req = 1'b0;
    chk("allocrel_count", 32'(count), 32'h1);
    chk("allocrel_cp_valid", 32'(cp_valid), 32'h4);
    tick(); tick();
    idle();
    chk("pre_rec_cp_valid", 32'(cp_valid), 32'hD);
    chk("pre_rec_count", 32'(count), 32'h3);

    // recover to slot 3 with head = 2
    rec_req = 1'b1; rec_id = 2'd3;
    #1;
    chk("rec_ready_blocked", 32'(alloc_ready), 32'h0);
    tick();
    rec_req = 1'b0;
    chk("rec_cp_valid", 32'(cp_valid), 32'h4);
    chk("rec_count", 32'(count), 32'h1);
    chk("rec_tail", 32'(alloc_id), 32'h3);

    // back to three entries, then flush with a pending alloc
    alloc_req = 1'b1;
    tick(); tick();
    idle();
    chk("pre_flush_count", 32'(count), 32'h3);
    flush = 1'b1; alloc_req = 1'b1;
    #1;
    chk("flush_ready", 32'(alloc_ready), 32'h0);
    tick();
    idle();
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_cp_valid", 32'(cp_valid), 32'h0);
    chk("flush_empty", 32'(empty), 32'h1);
    chk("flush_alloc_id", 32'(alloc_id), 32'h1);
    alloc_req = 1'b1;
    tick();
    idle();
    chk("post_flush_cp_valid", 32'(cp_valid), 32'h2);
    rel_req = 1'b1; rel_id = 2'd1;
    tick();
    idle();
    chk("post_flush_rel_count", 32'(count), 32'h0);
    chk("post_flush_rel_err", 32'(err), 32'h0);

    // release on an empty ring is a protocol error
    rel_req = 1'b1; rel_id = 2'd1;
    tick();
    idle();
    chk("bad_rel_err", 32'(err), 32'h1);
    chk("bad_rel_count", 32'(count), 32'h0);

    // reset clears err; recover to an invalid slot sets it
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_err", 32'(err), 32'h0);
    rec_req = 1'b1; rec_id = 2'd2;
    tick();
    rec_req = 1'b0;
    chk("bad_rec_err", 32'(err), 32'h1);
    chk("bad_rec_cp_valid", 32'(cp_valid), 32'h0);

    // four allocs from reset, then a fifth while full
    reset = 1'b1;
    tick();
    reset = 1'b0;
    alloc_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("seq_alloc_id", 32'(alloc_id), 32'(i));
      tick();
    end
    chk("seq_full", 32'(full), 32'h1);
    chk("seq_ready", 32'(alloc_ready), 32'h0);
    chk("seq_err_before", 32'(err), 32'h0);
    tick();
    idle();
    chk("ovf_err", 32'(err), 32'h1);
    chk("ovf_count", 32'(count), 32'h4);
    chk("ovf_cp_valid", 32'(cp_valid), 32'hF);
    chk("ovf_alloc_id", 32'(alloc_id), 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_rat_ckpt_ring.md
DECODE_RAT_CKPT_RING -- requirements
Module: decode_rat_ckpt_ring

Interface
REQ-001 SHALL have parameter NUM_CP, default 4: checkpoint slots, power of two, 2..16.
REQ-002 SHALL have parameter NUM_AREG, default 32: architectural registers; reg 0 not stored, reads 0.
REQ-003 SHALL have parameters FID_W, default 8, and ROB_W, default 4: per-entry fid and rob widths.
REQ-004 clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 flush  in  1  snoop hit; drops all checkpoints.
REQ-006 alloc_req  in  1; alloc_ready  out  1; alloc_id  out  log2(NUM_CP)  slot taken on alloc_req&&alloc_ready.
REQ-007 alloc_valid  in  NUM_AREG; alloc_fid  in  NUM_AREG*FID_W; alloc_rob  in  NUM_AREG*ROB_W  snapshot written on alloc.
REQ-008 rec_req  in  1; rec_id  in  log2(NUM_CP); rec_valid/rec_fid/rec_rob  out  NUM_AREG/NUM_AREG*FID_W/NUM_AREG*ROB_W  combinational snapshot of rec_id.
REQ-009 cmt_req  in  1; cmt_areg  in  log2(NUM_AREG); cmt_fid  in  FID_W  entry commit.
REQ-010 rel_req  in  1; rel_id  in  log2(NUM_CP)  oldest-checkpoint release on branch commit.
REQ-011 cp_valid  out  NUM_CP; count  out  log2(NUM_CP)+1; full, empty  out  1; err  out  1 sticky protocol error.

Function
REQ-012 Slots SHALL form an age-ordered ring: head = oldest, tail = next alloc slot; alloc_id = tail.
REQ-013 alloc_ready SHALL be !full && !rec_req && !flush, from registered count only (no release-to-ready path).
REQ-014 Accepted alloc SHALL, next edge, write snapshot to slot tail, set cp_valid[tail], tail+1 mod NUM_CP, count+1.
REQ-015 Commit SHALL clear entry valid bit cmt_areg in every valid slot whose stored fid equals cmt_fid, next edge.
REQ-016 Commit coinciding with accepted alloc SHALL also match against alloc_fid for cmt_areg; match stores 0.
REQ-017 rec_valid SHALL show same-cycle commit effect: bit cmt_areg forced 0 if stored fid matches cmt_fid.
REQ-018 rec_fid/rec_rob SHALL be stored values, 1-cycle-free combinational read of rec_id.
REQ-019 Recover (rec_req, cp_valid[rec_id]) SHALL invalidate rec_id and all younger slots; tail := rec_id; count := (rec_id-head) mod NUM_CP.
REQ-020 Release valid only when rel_id == head and cp_valid[head]: clears head, head+1, count-1.
REQ-021 Recover and release same cycle: both apply unless rec_id == head, then release absorbed (ring empty, head := tail := rec_id).
REQ-022 Priority: reset > flush > recover > release > alloc; flush empties ring, pointers keep values, head := tail.
REQ-023 err SHALL set on: rec_req to invalid slot, rel_req with rel_id != head or empty, alloc_req when full; offending op ignored.
REQ-024 full = (count == NUM_CP); empty = (count == 0); pointers wrap mod NUM_CP.

Reset
REQ-025 Reset SHALL clear cp_valid, all entry valid bits, head, tail, count, err; full=0, empty=1, alloc_ready=1 post-reset.
REQ-026 fid/rob storage SHALL NOT be reset; reset mid-alloc/recover SHALL discard the operation.

Structure
REQ-027 Shared package SHALL hold default NUM_CP/NUM_AREG/FID_W/ROB_W and a ckpt-id width function.
REQ-028 One sub-module decode_rat_ckpt_slot (one snapshot: write, commit-clear, bypassed read), instantiated NUM_CP times; ring control in top.

Verification
REQ-029 Reset, 4 allocs (defaults) -> alloc_id 0,1,2,3; count=4, full=1, alloc_ready=0; 5th alloc_req -> err=1, state unchanged.
REQ-030 Alloc slot0 with areg5 fid 0x3A valid; cmt areg5 fid 0x3A while rec_id=0 -> rec_valid[5]=0 same cycle, stays 0 next cycle.
REQ-031 Alloc+commit same cycle, areg7 alloc_fid=cmt_fid=0x11 -> slot stored with valid[7]=0.
REQ-032 head=2, slots 2,3,0 valid, rec_id=3 -> cp_valid=0b0100, tail=3, count=1.
REQ-033 Full ring, rel_id=head and rec_id=head+1 same cycle -> count=0, empty=1, err=0.
REQ-034 Flush with count=3 plus alloc_req -> count=0, no alloc, cp_valid=0; next alloc_id = previous tail.
